// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
// Scans a SIZE-column, WIDTH-row common-row LED matrix. Once per frame it
// copies the pattern array into a shadow buffer, so a shift in progress
// upstream never shows up as a torn frame. Each column gets an all-off
// blanking gap, then DWELL cycles of drive with 4-bit PWM on the rows.
// Outputs decode the registered state and counters directly, so they
// change in the same cycle as the state that produces them.

module led_matrix_scanner #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 16,
  parameter int DWELL = 1000,
  parameter int BLANK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        frame_in [SIZE-1:0],
  input  logic [3:0]              brightness,
  output logic [$clog2(SIZE)-1:0] col_sel,
  output logic [SIZE-1:0]         col_onehot,
  output logic [WIDTH-1:0]        row_out,
  output logic                    frame_done
);

  localparam int COL_W = $clog2(SIZE);
  // One counter times both the blanking gap and the drive dwell.
  localparam int CNT_W = $clog2(DWELL + BLANK + 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'((BLANK > 0) ? (BLANK - 1) : 0);
  localparam logic [3:0]       PWM_LAST  = 4'd14;
  localparam logic [SIZE-1:0]  COL_BIT0  = {{(SIZE-1){1'b0}}, 1'b1};
  // With no blanking configured, every column goes straight to drive.
  localparam state_t           POST_GAP  = (BLANK > 0) ? S_BLANK : S_DRIVE;

  state_t             state_q;
  logic [COL_W-1:0]   col_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         pwm_q;
  logic [3:0]         bright_q;
  logic               first_frame_q;
  logic [WIDTH-1:0]   shadow_q [SIZE];

  // Scan sequencer: frame load, per-column blank/drive timing, PWM phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_LOAD;
      col_q         <= '0;
      cnt_q         <= '0;
      pwm_q         <= 4'd0;
      bright_q      <= 4'd0;
      first_frame_q <= 1'b1;
      for (int c = 0; c < SIZE; c++) begin
        shadow_q[c] <= '0;
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          // The only point where upstream data and brightness are taken in.
          for (int c = 0; c < SIZE; c++) begin
            shadow_q[c] <= frame_in[c];
          end
          bright_q      <= brightness;
          col_q         <= '0;
          cnt_q         <= '0;
          pwm_q         <= 4'd0;
          first_frame_q <= 1'b0;
          state_q       <= POST_GAP;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_END) begin
            cnt_q   <= '0;
            pwm_q   <= 4'd0;
            state_q <= S_DRIVE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        S_DRIVE: begin
          if (cnt_q == DWELL_END) begin
            cnt_q <= '0;
            // PWM phase restarts on every drive entry.
            pwm_q <= 4'd0;
            if (col_q == LAST_COL) begin
              // Columns only wrap through a fresh frame load.
              col_q   <= '0;
              state_q <= S_LOAD;
            end else begin
              col_q   <= col_q + COL_W'(1);
              state_q <= POST_GAP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            pwm_q <= (pwm_q == PWM_LAST) ? 4'd0 : (pwm_q + 4'd1);
          end
        end
        default: begin
          state_q <= S_LOAD;
          col_q   <= '0;
          cnt_q   <= '0;
          pwm_q   <= 4'd0;
        end
      endcase
    end
  end

  // Pin decode: column enable only in drive, rows gated by the PWM phase.
  always_comb begin
    col_sel    = col_q;
    col_onehot = '0;
    row_out    = '0;
    frame_done = 1'b0;
    case (state_q)
      S_LOAD: begin
        // The very first load after reset does not close a frame.
        frame_done = ~first_frame_q;
      end
      S_BLANK: begin
        col_onehot = '0;
      end
      S_DRIVE: begin
        col_onehot = COL_BIT0 << col_q;
        if (pwm_q < bright_q) begin
          row_out = shadow_q[col_q];
        end else begin
          row_out = '0;
        end
      end
      default: begin
        col_onehot = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner with SIZE=16, WIDTH=8, DWELL=30, BLANK=2.
// The reference model derives every output from the cycle index within a
// frame and a snapshot of the inputs taken at each frame start.

module tb_led_matrix_scanner;

  localparam int WIDTH = 8;
  localparam int SIZE  = 16;
  localparam int DWELL = 30;
  localparam int BLANK = 2;
  localparam int SLOT  = BLANK + DWELL;
  localparam int FRAME = 1 + SIZE * SLOT;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] frame_in [SIZE-1:0];
  logic [3:0]       brightness = 4'd0;
  logic [3:0]       col_sel;
  logic [SIZE-1:0]  col_onehot;
  logic [WIDTH-1:0] row_out;
  logic             frame_done;
  logic [28:0]      obs;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int t        = 0;
  logic [WIDTH-1:0] snap [SIZE];
  int snap_b = 0;

  led_matrix_scanner #(.WIDTH(WIDTH), .SIZE(SIZE), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_in   (frame_in),
    .brightness (brightness),
    .col_sel    (col_sel),
    .col_onehot (col_onehot),
    .row_out    (row_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  assign obs = {frame_done, col_sel, col_onehot, row_out};

  // Expected {frame_done, col_sel, col_onehot, row_out} at cycle tt after reset.
  function automatic logic [28:0] model_out(int tt);
    int pos, k, c, r, d;
    logic fd;
    logic [3:0] cs;
    logic [15:0] oh;
    logic [7:0] row;
    fd = 1'b0; cs = 4'd0; oh = 16'd0; row = 8'd0;
    pos = tt % FRAME;
    if (pos == 0) begin
      fd = (tt >= FRAME);
    end else begin
      k = pos - 1;
      c = k / SLOT;
      r = k % SLOT;
      cs = 4'(c);
      if (r >= BLANK) begin
        d = r - BLANK;
        oh = 16'd1 << c;
        if ((d % 15) < snap_b) row = snap[c];
      end
    end
    return {fd, cs, oh, row};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
  endtask

  // Moves one cycle on; frame starts capture the inputs as the model's snapshot.
  task automatic advance();
    if (t % FRAME == 0) begin
      for (int c = 0; c < SIZE; c++) snap[c] = frame_in[c];
      snap_b = int'(brightness);
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic rand_frame();
    for (int c = 0; c < SIZE; c++) frame_in[c] = 8'($urandom_range(1, 255));
  endtask

  task automatic test_reset();
    rand_frame();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_cnt++;
      if (obs !== 29'd0) $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, 29'd0);
      else pass_cnt++;
    end
    rst = 1'b0;
    t = 0;
    chk_cnt++;
    if (obs !== 29'd0) $display("FAIL reset_cycle0 got=%h exp=%h", obs, 29'd0);
    else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      chk_cnt++;
      if (obs !== model_out(t)) $display("FAIL reset_run t=%0d got=%h exp=%h", t, obs, model_out(t));
      else pass_cnt++;
      advance();
    end
  endtask

  task automatic test_timing();
    do_reset();
    brightness = 4'd15;
    rand_frame();
    frame_in[0] = 8'hFF;
    frame_in[1] = 8'h40;
    for (int i = 0; i < 1100; i++) begin
      chk_cnt++;
      if (obs !== model_out(t)) $display("FAIL timing t=%0d got=%h exp=%h", t, obs, model_out(t));
      else pass_cnt++;
      if (t == 1 || t == 2 || t == 33) begin
        chk_cnt++;
        if ({col_onehot, row_out, frame_done} !== 25'd0)
          $display("FAIL timing_blank t=%0d got=%h exp=0", t, {col_onehot, row_out, frame_done});
        else pass_cnt++;
      end
      if (t == 3 || t == 32) begin
        chk_cnt++;
        if ({col_onehot, row_out} !== {16'h0001, 8'hFF})
          $display("FAIL timing_col0 t=%0d got=%h exp=%h", t, {col_onehot, row_out}, {16'h0001, 8'hFF});
        else pass_cnt++;
      end
      if (t == 35 || t == 64) begin
        chk_cnt++;
        if ({col_sel, col_onehot, row_out} !== {4'd1, 16'h0002, 8'h40})
          $display("FAIL timing_col1 t=%0d got=%h exp=%h", t, {col_sel, col_onehot, row_out}, {4'd1, 16'h0002, 8'h40});
        else pass_cnt++;
      end
      if (t == 512 || t == 513 || t == 514) begin
        chk_cnt++;
        if (frame_done !== (t == 513))
          $display("FAIL timing_frame_done t=%0d got=%b exp=%b", t, frame_done, (t == 513));
        else pass_cnt++;
      end
      advance();
    end
  endtask

  task automatic test_tear_free();
    do_reset();
    brightness = 4'd15;
    rand_frame();
    frame_in[5] = 8'h00;
    for (int i = 0; i < 720; i++) begin
      if (t == 100) frame_in[5] = 8'hAA;
      chk_cnt++;
      if (obs !== model_out(t)) $display("FAIL tear t=%0d got=%h exp=%h", t, obs, model_out(t));
      else pass_cnt++;
      if (t == 170 || t == 513 + 170) begin
        chk_cnt++;
        if ({col_sel, col_onehot, row_out} !== {4'd5, 16'h0020, (t == 170) ? 8'h00 : 8'hAA})
          $display("FAIL tear_col5 t=%0d got=%h exp=%h", t, {col_sel, col_onehot, row_out},
                   {4'd5, 16'h0020, (t == 170) ? 8'h00 : 8'hAA});
        else pass_cnt++;
      end
      advance();
    end
  endtask

  task automatic test_pwm();
    int on_cnt [SIZE];
    int total_on;
    logic [15:0] seen;
    do_reset();
    brightness = 4'd4;
    rand_frame();
    for (int c = 0; c < SIZE; c++) on_cnt[c] = 0;
    for (int i = 0; i < FRAME; i++) begin
      chk_cnt++;
      if (obs !== model_out(t)) $display("FAIL pwm4 t=%0d got=%h exp=%h", t, obs, model_out(t));
      else pass_cnt++;
      for (int c = 0; c < SIZE; c++)
        if (col_onehot == (16'd1 << c) && row_out != 8'd0) on_cnt[c]++;
      advance();
    end
    for (int c = 0; c < SIZE; c++) begin
      chk_cnt++;
      if (on_cnt[c] != 8) $display("FAIL pwm4_on col=%0d got=%0d exp=8", c, on_cnt[c]);
      else pass_cnt++;
    end
    do_reset();
    brightness = 4'd0;
    rand_frame();
    total_on = 0;
    seen = 16'd0;
    for (int i = 0; i < FRAME; i++) begin
      chk_cnt++;
      if (obs !== model_out(t)) $display("FAIL pwm0 t=%0d got=%h exp=%h", t, obs, model_out(t));
      else pass_cnt++;
      if (row_out != 8'd0) total_on++;
      seen = seen | col_onehot;
      advance();
    end
    chk_cnt++;
    if (total_on != 0 || seen !== 16'hFFFF)
      $display("FAIL pwm0_scan got on=%0d seen=%h exp on=0 seen=ffff", total_on, seen);
    else pass_cnt++;
  endtask

  task automatic test_bright_change();
    int onc [2][SIZE];
    int f;
    do_reset();
    brightness = 4'd15;
    rand_frame();
    for (int a = 0; a < 2; a++) for (int c = 0; c < SIZE; c++) onc[a][c] = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (t == 200) brightness = 4'd2;
      chk_cnt++;
      if (obs !== model_out(t)) $display("FAIL bright t=%0d got=%h exp=%h", t, obs, model_out(t));
      else pass_cnt++;
      f = t / FRAME;
      for (int c = 0; c < SIZE; c++)
        if (col_onehot == (16'd1 << c) && row_out != 8'd0) onc[f][c]++;
      advance();
    end
    for (int c = 0; c < SIZE; c += 5) begin
      chk_cnt++;
      if (onc[0][c] != 30 || onc[1][c] != 4)
        $display("FAIL bright_duty col=%0d got=%0d/%0d exp=30/4", c, onc[0][c], onc[1][c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    brightness = 4'($urandom_range(1, 15));
    rand_frame();
    for (int i = 0; i < 240; i++) begin
      chk_cnt++;
      if (obs !== model_out(t)) $display("FAIL midrst_pre t=%0d got=%h exp=%h", t, obs, model_out(t));
      else pass_cnt++;
      advance();
    end
    chk_cnt++;
    if (col_onehot !== 16'h0080) $display("FAIL midrst_col7 got=%h exp=%h", col_onehot, 16'h0080);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
    chk_cnt++;
    if (obs !== 29'd0) $display("FAIL midrst_zero got=%h exp=%h", obs, 29'd0);
    else pass_cnt++;
    for (int i = 0; i < 600; i++) begin
      chk_cnt++;
      if (obs !== model_out(t)) $display("FAIL midrst_post t=%0d got=%h exp=%h", t, obs, model_out(t));
      else pass_cnt++;
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    brightness = 4'($urandom_range(0, 15));
    rand_frame();
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 3) == 0) frame_in[$urandom_range(0, SIZE - 1)] = 8'($urandom);
      if ($urandom_range(0, 20) == 0) brightness = 4'($urandom);
      chk_cnt++;
      if (obs !== model_out(t)) $display("FAIL random t=%0d got=%h exp=%h", t, obs, model_out(t));
      else pass_cnt++;
      advance();
    end
  endtask

  initial begin
    for (int c = 0; c < SIZE; c++) frame_in[c] = 8'd0;
    test_reset();
    test_timing();
    test_tear_free();
    test_pwm();
    test_bright_change();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Downstream consumer of the circular shift register's SIZE x WIDTH register array. Each array entry is one column pattern.
- Snapshots the array once per frame into a shadow buffer, so the display never shows a half-shifted frame.
- Multiplexes the columns one at a time onto a common-row LED matrix, with a blanking gap between columns and 4-bit PWM brightness on the row lines.
- Sits between the pattern generator and the board column/row pins.

Parameters:
WIDTH, 8, bits per column (number of row lines)
SIZE, 16, number of columns (entries in frame_in)
DWELL, 1000, clock cycles each column is driven; must be >= 1
BLANK, 4, all-off cycles before each column; 0 = no blanking state

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
frame_in  input  [WIDTH-1:0] x [SIZE-1:0] unpacked array  column patterns from the shift register; entry c drives column c
brightness  input  4  PWM duty, 0 = off, 15 = full on
col_sel  output  $clog2(SIZE)  index of the column currently being scanned
col_onehot  output  SIZE  column enable, bit c high only while column c is in DRIVE
row_out  output  WIDTH  row drive, bit i = shadow[c][i] gated by PWM
frame_done  output  1  single-cycle pulse at each frame boundary

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst high at a clk edge):
  - state=LOAD, col=0, dwell/blank/pwm counters=0, first_frame=1.
  - Shadow buffer and latched brightness cleared to 0.
  - Outputs: row_out=0, col_onehot=0, col_sel=0, frame_done=0.
  - Reset overrides everything, including mid-DRIVE. Outputs are zero in the cycle after the reset edge.
- Outputs are combinational decodes of registered state and counters. There is no extra output latency.
- FSM states:
  - LOAD (1 cycle): shadow <= frame_in; bright_l <= brightness; col <= 0. frame_done=1 if first_frame==0; first_frame <= 0. Next state is BLANK if BLANK>0, else DRIVE.
  - BLANK (BLANK cycles): col_onehot=0, row_out=0, col_sel=col. Go to DRIVE after the count expires.
  - DRIVE (DWELL cycles):
    - col_onehot = 1<<col, col_sel = col.
    - pwm counts 0..14 and wraps; it restarts at 0 on every DRIVE entry.
    - row_out = shadow[col] when pwm < bright_l, else 0.
    - At the end of the count: if col==SIZE-1, go to LOAD; else col++ and go to BLANK (or DRIVE if BLANK==0).
- Frame period = 1 + SIZE*(BLANK+DWELL) cycles. With defaults this is 16065.
- Tear-free rule: frame_in and brightness are sampled only in LOAD. Changes at any other time have no effect until the next LOAD.
- Brightness: 15 means rows are on every DRIVE cycle; 0 means rows are always 0 while columns still scan.
- Column wrap: col goes from SIZE-1 back to 0 through LOAD only. col_onehot is never multi-hot and is never active outside DRIVE.
- frame_done is never asserted in the first LOAD after reset.

Test Plan:
All tests use SIZE=16, WIDTH=8, DWELL=30, BLANK=2; cycle 0 is the first cycle after rst deasserts.
1. Reset: hold rst high 3 cycles with frame_in non-zero -> row_out=0, col_onehot=0, col_sel=0, frame_done=0 throughout. Cycle 0 is LOAD with frame_done=0.
2. Timing, brightness=15, frame_in[0]=8'hFF, frame_in[1]=8'h40 ->
   - cycles 1-2: all outputs 0.
   - cycles 3-32: col_onehot=16'h0001, row_out=8'hFF.
   - cycles 33-34: blank.
   - cycles 35-64: col_onehot=16'h0002, col_sel=1, row_out=8'h40.
   - cycle 513: LOAD with frame_done=1, high for exactly one cycle.
3. Tear-free: change frame_in[5] from 8'h00 to 8'hAA at cycle 100 -> column 5 (cycles 163-192) shows 8'h00. After the next LOAD, column 5 of frame 2 shows 8'hAA.
4. PWM: brightness=4 -> within each 30-cycle DRIVE, row_out=data on pwm phases 0-3 of each 15-cycle period (8 on-cycles), else 0. brightness=0 -> row_out=0 always while col_onehot still steps 0..15.
5. Brightness change mid-frame: set brightness 15 to 2 at cycle 200 -> duty unchanged until cycle 513. From the next frame, 4 on-cycles per column.
6. Reset mid-operation: assert rst for 1 cycle during column 7 DRIVE -> outputs 0 on the next cycle. The scan restarts with LOAD, and the post-reset LOAD has frame_done=0.
